// File: rtl/ps2_kbd_pkg.sv
// Shared types and scancode constants for the PS/2 set-2 keyboard decoder.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;

    // Letters arrive lowercase from the table; raise them when shift XOR caps.
    function automatic logic [7:0] apply_case(input logic [7:0] ch, input logic upper);
        logic is_letter;
        is_letter = (ch >= 8'h61) && (ch <= 8'h7A);
        return (is_letter && upper) ? (ch - 8'h20) : ch;
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to ASCII table; letters come out lowercase.
module ps2_scan2ascii (
    input  logic [7:0] scan_code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o,
    output logic       hit_o
);

    logic [7:0] lo;
    logic [7:0] hi;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lo    = 8'h00;
        hi    = 8'h00;
        hit_o = 1'b1;
        unique case (scan_code_i)
            8'h1C: lo = "a";   8'h32: lo = "b";   8'h21: lo = "c";   8'h23: lo = "d";
            8'h24: lo = "e";   8'h2B: lo = "f";   8'h34: lo = "g";   8'h33: lo = "h";
            8'h43: lo = "i";   8'h3B: lo = "j";   8'h42: lo = "k";   8'h4B: lo = "l";
            8'h3A: lo = "m";   8'h31: lo = "n";   8'h44: lo = "o";   8'h4D: lo = "p";
            8'h15: lo = "q";   8'h2D: lo = "r";   8'h1B: lo = "s";   8'h2C: lo = "t";
            8'h3C: lo = "u";   8'h2A: lo = "v";   8'h1D: lo = "w";   8'h22: lo = "x";
            8'h35: lo = "y";   8'h1A: lo = "z";
            8'h29: lo = " ";
            8'h45: {lo, hi} = {"0", ")"};
            8'h16: {lo, hi} = {"1", "!"};
            8'h1E: {lo, hi} = {"2", "@"};
            8'h26: {lo, hi} = {"3", "#"};
            8'h25: {lo, hi} = {"4", "$"};
            8'h2E: {lo, hi} = {"5", "%"};
            8'h36: {lo, hi} = {"6", "^"};
            8'h3D: {lo, hi} = {"7", "&"};
            8'h3E: {lo, hi} = {"8", "*"};
            8'h46: {lo, hi} = {"9", "("};
            8'h0E: {lo, hi} = {8'h60, "~"};
            8'h4E: {lo, hi} = {"-", "_"};
            8'h55: {lo, hi} = {"=", "+"};
            8'h54: {lo, hi} = {"[", "{"};
            8'h5B: {lo, hi} = {"]", "}"};
            8'h5D: {lo, hi} = {"\\", "|"};
            8'h4C: {lo, hi} = {";", ":"};
            8'h52: {lo, hi} = {"'", "\""};
            8'h41: {lo, hi} = {",", "<"};
            8'h49: {lo, hi} = {".", ">"};
            8'h4A: {lo, hi} = {"/", "?"};
            default: hit_o = 1'b0;
        endcase
        // Letters carry no shifted glyph; their case is decided by the parent.
        ascii_o = (shift_i && (hi != 8'h00)) ? hi : lo;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to ASCII with break/extended handling, Shift, Caps Lock and prefix timeout.
// Build macro KBD_AUTOREPEAT_EN: typematic repeats emit characters; undefined: one pulse per press.
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter logic [7:0] ENTER_ASCII = 8'd10,
    parameter int         SEQ_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] ascii_out,
    output logic       p_valid,
    output logic       shift_o,
    output logic       caps_o,
    output logic       seq_err
);

    localparam int              CTR_W    = $clog2(SEQ_TIMEOUT) + 1;
    localparam logic [CTR_W-1:0] TMO_LAST = CTR_W'(SEQ_TIMEOUT - 1);

`ifdef KBD_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    kbd_state_e       state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [7:0]       ascii_q, ascii_d;
    logic             p_valid_q, p_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             caps_q, caps_d;
    logic [7:0]       held_q, held_d;

    logic [7:0] lut_ascii;
    logic       lut_hit;
    logic       shift;
    logic       timeout;
    logic       is_repeat;
    logic       emit_req;
    logic [7:0] emit_char;

    assign shift     = lshift_q | rshift_q;
    assign is_repeat = (scan_code == held_q);
    // An arriving byte always beats an expiring timeout.
    assign timeout   = (state_q != ST_IDLE) && !scan_valid && (ctr_q == TMO_LAST);

    ps2_scan2ascii u_lut (
        .scan_code_i (scan_code),
        .shift_i     (shift),
        .ascii_o     (lut_ascii),
        .hit_o       (lut_hit)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK)    state_d = ST_BRK;
                    else if (scan_code == SC_EXT) state_d = ST_EXT;
                end
                ST_EXT:  state_d = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        caps_d    = caps_q;
        held_d    = held_q;
        ascii_d   = ascii_q;
        emit_req  = 1'b0;
        emit_char = 8'h00;
        seq_err_d = timeout;
        ctr_d     = (scan_valid || state_q == ST_IDLE || timeout) ? '0 : ctr_q + 1'b1;

        if (scan_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_code != SC_BREAK && scan_code != SC_EXT) begin
                        held_d = scan_code;
                        unique case (scan_code)
                            SC_LSHIFT: lshift_d = 1'b1;
                            SC_RSHIFT: rshift_d = 1'b1;
                            SC_CAPS:   if (!is_repeat) caps_d = ~caps_q;
                            SC_ENTER: begin
                                emit_req  = AUTOREPEAT || !is_repeat;
                                emit_char = ENTER_ASCII;
                            end
                            default: begin
                                emit_req  = lut_hit && (AUTOREPEAT || !is_repeat);
                                emit_char = apply_case(lut_ascii, shift ^ caps_q);
                            end
                        endcase
                    end
                end
                ST_BRK: begin
                    if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
                    if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
                    if (scan_code == held_q)    held_d   = 8'h00;
                end
                ST_EXT: begin
                    if (scan_code == SC_ENTER) begin
                        emit_req  = 1'b1;
                        emit_char = ENTER_ASCII;
                    end else if (scan_code == SC_KP_SLASH) begin
                        emit_req  = 1'b1;
                        emit_char = "/";
                    end
                end
                default: ;
            endcase
        end

        // Back-to-back bytes must never stretch the strobe into two cycles.
        p_valid_d = emit_req && !p_valid_q;
        if (p_valid_d) ascii_d = emit_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q     <= '0;
            ascii_q   <= 8'h00;
            p_valid_q <= 1'b0;
            seq_err_q <= 1'b0;
            lshift_q  <= 1'b0;
            rshift_q  <= 1'b0;
            caps_q    <= 1'b0;
            held_q    <= 8'h00;
        end else begin
            ctr_q     <= ctr_d;
            ascii_q   <= ascii_d;
            p_valid_q <= p_valid_d;
            seq_err_q <= seq_err_d;
            lshift_q  <= lshift_d;
            rshift_q  <= rshift_d;
            caps_q    <= caps_d;
            held_q    <= held_d;
        end
    end

    assign ascii_out = ascii_q;
    assign p_valid   = p_valid_q;
    assign shift_o   = shift;
    assign caps_o    = caps_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder; expected characters are queued as bytes are driven.
module tb_ps2_key_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [7:0] ascii_out;
    logic       p_valid;
    logic       shift_o;
    logic       caps_o;
    logic       seq_err;

    int         vectors     = 0;
    int         miscompares = 0;
    int         pulse_cnt   = 0;
    int         seq_err_cnt = 0;
    logic       prev_pv     = 1'b0;
    logic [7:0] sb_q[$];

`ifdef KBD_AUTOREPEAT_EN
    localparam int REPEAT_PULSES = 3;
`else
    localparam int REPEAT_PULSES = 1;
`endif

    ps2_key_decoder #(
        .ENTER_ASCII (8'd10),
        .SEQ_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .ascii_out  (ascii_out),
        .p_valid    (p_valid),
        .shift_o    (shift_o),
        .caps_o     (caps_o),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (p_valid) begin
            check("pv_single_cycle", 32'(prev_pv), 32'd0);
            check("pv_vs_seq_err", 32'(seq_err), 32'd0);
            if (sb_q.size() == 0) begin
                check("spurious_pulse", 32'(p_valid), 32'd0);
            end else begin
                logic [7:0] exp_c;
                exp_c = sb_q.pop_front();
                check("ascii", 32'(ascii_out), 32'(exp_c));
            end
            pulse_cnt++;
        end
        if (seq_err) seq_err_cnt++;
        prev_pv = p_valid;
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        scan_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_char(input logic [7:0] c);
        sb_q.push_back(c);
    endtask

    task automatic settle(input string tag, input int base, input int n);
        repeat (4) @(negedge clk);
        check({tag, "_pulses"}, 32'(pulse_cnt - base), 32'(n));
        check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int err_base;
        int lat;

        reset      = 1'b1;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ascii", 32'(ascii_out), 32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_shift", 32'(shift_o), 32'h0);
        check("rst_caps", 32'(caps_o), 32'h0);
        check("rst_seq_err", 32'(seq_err), 32'h0);

        // Plain press and release.
        base = pulse_cnt; err_base = seq_err_cnt;
        expect_char("a");
        send(8'h1C); send(8'hF0); send(8'h1C);
        settle("t1", base, 1);
        check("t1_seq_err", 32'(seq_err_cnt - err_base), 32'd0);
        check("t1_hold", 32'(ascii_out), 32'h61);

        // Shift held around a letter.
        do_reset();
        base = pulse_cnt;
        expect_char("A");
        send(8'h12); check("t2_shift_on", 32'(shift_o), 32'd1);
        send(8'h1C); send(8'hF0); send(8'h1C);
        check("t2_shift_still", 32'(shift_o), 32'd1);
        send(8'hF0); send(8'h12);
        check("t2_shift_off", 32'(shift_o), 32'd0);
        settle("t2", base, 1);

        // Caps Lock, shift cancelling caps, shifted digit.
        do_reset();
        base = pulse_cnt;
        send(8'h58); send(8'hF0); send(8'h58);
        check("t3_caps_on", 32'(caps_o), 32'd1);
        expect_char("A"); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h12);
        expect_char("a"); send(8'h1C);
        expect_char("!"); send(8'h16);
        settle("t3", base, 3);

        // Caps Lock typematic repeat must not toggle.
        do_reset();
        send(8'h58); send(8'h58);
        check("caps_repeat", 32'(caps_o), 32'd1);
        send(8'hF0); send(8'h58); send(8'h58);
        check("caps_second_press", 32'(caps_o), 32'd0);

        // Enter, extended Enter, keypad slash, dropped and discarded extended codes.
        do_reset();
        base = pulse_cnt;
        expect_char(8'h0A); send(8'h5A); send(8'hF0); send(8'h5A);
        expect_char(8'h0A); send(8'hE0); send(8'h5A);
        expect_char("/");   send(8'hE0); send(8'h4A);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h5A);
        expect_char("a");   send(8'h1C);
        settle("t4", base, 4);

        // Typematic repeat.
        do_reset();
        base = pulse_cnt;
        for (int i = 0; i < REPEAT_PULSES; i++) expect_char("a");
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        settle("t5", base, REPEAT_PULSES);

        // Prefix timeout: F0 then silence.
        do_reset();
        base = pulse_cnt; err_base = seq_err_cnt;
        @(negedge clk); scan_code = 8'hF0; scan_valid = 1'b1;
        @(negedge clk); scan_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (seq_err && lat < 0) lat = i;
        end
        check("t6_seq_err_latency", 32'(lat), 32'd16);
        check("t6_seq_err_count", 32'(seq_err_cnt - err_base), 32'd1);
        expect_char("a"); send(8'h1C);
        settle("t6", base, 1);

        // Byte arriving on the exact timeout cycle wins.
        do_reset();
        base = pulse_cnt; err_base = seq_err_cnt;
        send(8'h12);
        @(negedge clk); scan_code = 8'hF0; scan_valid = 1'b1;
        @(negedge clk); scan_valid = 1'b0;
        repeat (14) @(negedge clk);
        send(8'h12);
        repeat (20) @(negedge clk);
        check("t6b_break_taken", 32'(shift_o), 32'd0);
        check("t6b_no_seq_err", 32'(seq_err_cnt - err_base), 32'd0);
        expect_char("a"); send(8'h1C);
        settle("t6b", base, 1);

        // Reset one cycle after E0 clears everything.
        do_reset();
        base = pulse_cnt;
        send(8'h58); send(8'h12);
        check("t7_caps_pre", 32'(caps_o), 32'd1);
        @(negedge clk); scan_code = 8'hE0; scan_valid = 1'b1;
        @(negedge clk); scan_valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("t7_caps_cleared", 32'(caps_o), 32'd0);
        check("t7_shift_cleared", 32'(shift_o), 32'd0);
        expect_char(8'h0A); send(8'h5A);
        settle("t7", base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
